overcurrent_monitor: RTL and testbench
======================================

Name: overcurrent_monitor

Overview:
- Sits directly downstream of the current sensor: consumes raw 12-bit motor-current samples and produces a boxcar-averaged current.
- Drives a registered kill line into the motor controller's reset input.
- Trips after a run of consecutive high averages, waits for current to fall below a hysteresis level, enforces a cooldown, then holds the fault latched until operator acknowledge.
- avg_out feeds the seven-segment display path.

Parameters:
- DATA_W, 12, sample and average width.
- AVG_LOG2, 3, log2 of the averaging window (8 samples).
- TRIP_LEVEL, 12'd2048, average at or above this counts toward a trip.
- CLEAR_LEVEL, 12'd1536, average strictly below this permits recovery. Must be less than TRIP_LEVEL.
- TRIP_COUNT, 4, consecutive high averages needed to trip (legal range 1..15).
- COOLDOWN_CYCLES, 100000000, clk cycles of enforced off-time (1 s at 100 MHz).
- CNT_W, 27, cooldown counter width. Must satisfy 2^CNT_W > COOLDOWN_CYCLES.

Ports:
- clk, input, 1, system clock.
- reset, input, 1, synchronous active-high reset.
- sample_in, input, DATA_W, raw current sample.
- sample_valid, input, 1, one-cycle strobe qualifying sample_in.
- fault_ack, input, 1, level or pulse; clears a held fault (HOLD state only).
- avg_out, output, DATA_W, current windowed average.
- avg_valid, output, 1, one-cycle strobe when avg_out updates.
- motor_kill, output, 1, high means motor must be disabled.
- fault_latched, output, 1, sticky fault indicator.
- state_out, output, 2, FSM state encoding: NORMAL=0, TRIPPED=1, COOLDOWN=2, HOLD=3.

Behaviour:
- Reset: all outputs go to 0 and state goes to NORMAL. Also clear the window shift register (2^AVG_LOG2 entries), the running sum (DATA_W+AVG_LOG2 bits), the trip counter and the cooldown timer.
- Averaging, on sample_valid:
  - sum <= sum + sample_in - oldest_entry; shift sample_in into the window.
  - The following cycle: avg_out <= sum >> AVG_LOG2 (truncating) and avg_valid = 1 for exactly one cycle.
  - Latency: sample_valid to avg_valid is 1 cycle; avg_out holds between strobes.
  - After reset the window is zero-filled, so the average ramps up. No special-case for a partially filled window.
  - Back-to-back sample_valid on every cycle is supported with no loss of samples.
- The sum never overflows by construction: the width is exact for 2^AVG_LOG2 full-scale samples.
- All FSM decisions are evaluated only on avg_valid cycles, except the cooldown timer and fault_ack.
- NORMAL:
  - On avg_valid with avg >= TRIP_LEVEL: trip_cnt increments, saturating at TRIP_COUNT.
  - On avg_valid with avg < TRIP_LEVEL: trip_cnt <= 0.
  - When the increment reaches TRIP_COUNT, go to TRIPPED.
  - motor_kill and fault_latched go to 1 in the cycle after that avg_valid (registered).
  - trip_cnt is cleared on leaving NORMAL.
- TRIPPED:
  - On avg_valid with avg < CLEAR_LEVEL: go to COOLDOWN and load timer <= COOLDOWN_CYCLES-1.
  - Averages between CLEAR_LEVEL and TRIP_LEVEL keep the FSM in TRIPPED.
- COOLDOWN:
  - Timer decrements every cycle.
  - On avg_valid with avg >= TRIP_LEVEL: return to TRIPPED (timer abandoned). This check has priority over timer expiry in the same cycle.
  - When timer == 0 and no re-trip: go to HOLD.
- HOLD:
  - When fault_ack == 1: go to NORMAL; motor_kill and fault_latched go to 0 on the next cycle.
  - Averages are ignored in HOLD.
- fault_ack in any state other than HOLD is ignored. An ack asserted continuously through COOLDOWN takes effect on the first HOLD cycle (1-cycle HOLD).
- motor_kill = 1 in TRIPPED, COOLDOWN and HOLD; 0 in NORMAL. fault_latched tracks motor_kill.
- Reset mid-operation, including during COOLDOWN: immediate return to NORMAL with all state cleared. The motor is re-enabled.
- Averaging continues uninterrupted in every FSM state.

Test Plan:
- Setup: AVG_LOG2=3, TRIP_COUNT=4, COOLDOWN_CYCLES=16, CLEAR_LEVEL=1536, TRIP_LEVEL=2048.
- Ramp: 8 samples of 1000, one per 10 cycles -> avg_out sequence 125, 250, …, 1000. avg_valid is exactly 1 cycle after each sample_valid; motor_kill stays 0.
- Trip: window full of 3000, then 4 more samples of 3000 -> state_out=1 and motor_kill=1 exactly 1 cycle after the 4th avg_valid. Same stream with 3 highs then one 1000-average -> no trip.
- Hysteresis: after the trip, feed averages of 1800 -> FSM stays TRIPPED. Then feed 0s until avg < 1536 -> COOLDOWN.
- Re-trip: 3000s during COOLDOWN -> back to TRIPPED.
- Recovery: uninterrupted cooldown -> HOLD after 16 cycles, motor_kill still 1. Pulse fault_ack -> NORMAL, motor_kill=0 and fault_latched=0 next cycle.
- fault_ack pulsed in TRIPPED -> no effect.
- Reset asserted in COOLDOWN -> the next cycle shows all outputs 0 and state_out=0. A fresh sample of 800 then yields avg_out=100.

Source files
------------

// File: rtl/overcurrent_monitor.sv
// rtl/overcurrent_monitor.sv - boxcar-averaged motor current with trip/cooldown/hold kill FSM
module overcurrent_monitor #(
    parameter int                 DATA_W          = 12,
    parameter int                 AVG_LOG2        = 3,
    parameter logic [DATA_W-1:0]  TRIP_LEVEL      = 12'd2048,
    parameter logic [DATA_W-1:0]  CLEAR_LEVEL     = 12'd1536,
    parameter int                 TRIP_COUNT      = 4,
    parameter int                 COOLDOWN_CYCLES = 100000000,
    parameter int                 CNT_W           = 27
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              sample_valid,
    input  logic              fault_ack,
    output logic [DATA_W-1:0] avg_out,
    output logic              avg_valid,
    output logic              motor_kill,
    output logic              fault_latched,
    output logic [1:0]        state_out
);

    localparam int              WIN        = 1 << AVG_LOG2;
    localparam int              SUM_W      = DATA_W + AVG_LOG2;
    localparam logic [3:0]      TRIP_MAX   = 4'(TRIP_COUNT);
    localparam logic [CNT_W-1:0] TIMER_LOAD = CNT_W'(COOLDOWN_CYCLES - 1);

    typedef enum logic [1:0] {
        NORMAL   = 2'd0,
        TRIPPED  = 2'd1,
        COOLDOWN = 2'd2,
        HOLD     = 2'd3
    } state_t;

    logic [DATA_W-1:0] window [WIN];
    logic [SUM_W-1:0]  sum;
    logic [SUM_W-1:0]  sum_next;
    state_t            state;
    state_t            state_next;
    logic [3:0]        trip_cnt;
    logic [3:0]        trip_cnt_next;
    logic [CNT_W-1:0]  timer;
    logic [CNT_W-1:0]  timer_next;
    logic              avg_high;
    logic              avg_low;

    // Register the average from the updated sum so avg_valid lands one cycle after sample_valid.
    assign sum_next  = sum + SUM_W'(sample_in) - SUM_W'(window[WIN-1]);
    assign avg_high  = avg_valid && (avg_out >= TRIP_LEVEL);
    assign avg_low   = avg_valid && (avg_out < CLEAR_LEVEL);
    assign state_out = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < WIN; i++) begin
                window[i] <= '0;
            end
            sum           <= '0;
            avg_out       <= '0;
            avg_valid     <= 1'b0;
            state         <= NORMAL;
            trip_cnt      <= '0;
            timer         <= '0;
            motor_kill    <= 1'b0;
            fault_latched <= 1'b0;
        end else begin
            avg_valid <= sample_valid;
            if (sample_valid) begin
                window[0] <= sample_in;
                for (int i = 1; i < WIN; i++) begin
                    window[i] <= window[i-1];
                end
                sum     <= sum_next;
                avg_out <= sum_next[SUM_W-1:AVG_LOG2];
            end
            state         <= state_next;
            trip_cnt      <= trip_cnt_next;
            timer         <= timer_next;
            motor_kill    <= (state_next != NORMAL);
            fault_latched <= (state_next != NORMAL);
        end
    end

    always_comb begin
        state_next    = state;
        trip_cnt_next = trip_cnt;
        timer_next    = timer;
        case (state)
            NORMAL: begin
                if (avg_valid) begin
                    if (avg_high) begin
                        if (trip_cnt >= TRIP_MAX - 4'd1) begin
                            state_next    = TRIPPED;
                            trip_cnt_next = '0;
                        end else begin
                            trip_cnt_next = trip_cnt + 4'd1;
                        end
                    end else begin
                        trip_cnt_next = '0;
                    end
                end
            end
            TRIPPED: begin
                if (avg_low) begin
                    state_next = COOLDOWN;
                    timer_next = TIMER_LOAD;
                end
            end
            COOLDOWN: begin
                // A re-trip wins over timer expiry in the same cycle.
                if (avg_high) begin
                    state_next = TRIPPED;
                end else if (timer == '0) begin
                    state_next = HOLD;
                end else begin
                    timer_next = timer - 1'b1;
                end
            end
            HOLD: begin
                if (fault_ack) begin
                    state_next = NORMAL;
                end
            end
            default: state_next = NORMAL;
        endcase
    end

endmodule

// File: tb/tb_overcurrent_monitor.sv
// tb/tb_overcurrent_monitor.sv - table-driven and scoreboard bench for overcurrent_monitor
module tb_overcurrent_monitor;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [11:0] sample_in = '0;
    logic        sample_valid = 1'b0;
    logic        fault_ack = 1'b0;
    logic [11:0] avg_out;
    logic        avg_valid;
    logic        motor_kill;
    logic        fault_latched;
    logic [1:0]  state_out;

    overcurrent_monitor #(
        .DATA_W(12), .AVG_LOG2(3), .TRIP_LEVEL(12'd2048), .CLEAR_LEVEL(12'd1536),
        .TRIP_COUNT(4), .COOLDOWN_CYCLES(16), .CNT_W(5)
    ) dut (
        .clk(clk), .reset(reset), .sample_in(sample_in), .sample_valid(sample_valid),
        .fault_ack(fault_ack), .avg_out(avg_out), .avg_valid(avg_valid),
        .motor_kill(motor_kill), .fault_latched(fault_latched), .state_out(state_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct { int avg; int cyc; } exp_t;
    exp_t exp_q[$];
    int   mwin[8];
    int   msum = 0;

    typedef struct { int sample; int st; int kill; int gap; } vec_t;
    vec_t vecs[$];

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 8; i++) mwin[i] = 0;
        msum = 0;
        exp_q.delete();
    endtask

    task automatic drive(input int v);
        exp_t e;
        @(posedge clk); #1;
        sample_in    = 12'(v);
        sample_valid = 1'b1;
        msum = msum + v - mwin[7];
        for (int i = 7; i > 0; i--) mwin[i] = mwin[i-1];
        mwin[0] = v;
        e.avg = msum >> 3;
        e.cyc = cyc + 1;
        exp_q.push_back(e);
    endtask

    task automatic release_valid();
        @(posedge clk); #1;
        sample_valid = 1'b0;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic chk_state(input string name, input int st, input int kill);
        chk({name, "_state"}, int'(state_out), st);
        chk({name, "_kill"}, int'(motor_kill), kill);
        chk({name, "_fault"}, int'(fault_latched), kill);
    endtask

    // Scoreboard: each avg_valid strobe must match the oldest pending expectation.
    always @(negedge clk) begin
        if (avg_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL avg_spurious: got avg_valid=1 expected none pending (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("avg_out", int'(avg_out), e.avg);
                chk("avg_latency", cyc, e.cyc);
            end
        end
    end

    task automatic add(input int s, input int st, input int k, input int g);
        vec_t v;
        v.sample = s; v.st = st; v.kill = k; v.gap = g;
        vecs.push_back(v);
    endtask

    initial begin
        int prev_st;
        for (int i = 0; i < 8; i++) add(1000, 0, 0, 7);
        for (int i = 0; i < 8; i++) add(2000, 0, 0, 0);
        add(2400, 0, 0, 0);
        add(2000, 0, 0, 0);
        add(2000, 0, 0, 0);
        add(1000, 0, 0, 0);
        add(3000, 0, 0, 0);
        add(3000, 0, 0, 0);
        add(3000, 0, 0, 0);
        add(3000, 1, 1, 0);
        for (int i = 0; i < 8; i++) add(1800, 1, 1, 0);
        add(0, 1, 1, 0);
        add(0, 2, 1, 0);

        model_clear();
        repeat (3) step();
        chk("rst_avg_out", int'(avg_out), 0);
        chk("rst_avg_valid", int'(avg_valid), 0);
        chk_state("rst", 0, 0);
        reset = 1'b0;

        prev_st = 0;
        foreach (vecs[k]) begin
            drive(vecs[k].sample);
            release_valid();
            chk("vec_pre_state", int'(state_out), prev_st);
            step();
            chk_state($sformatf("vec%0d", k), vecs[k].st, vecs[k].kill);
            repeat (vecs[k].gap) step();
            prev_st = vecs[k].st;
        end

        // Re-trip while cooling down
        drive(4095); drive(4095); drive(4095);
        release_valid();
        step();
        chk_state("retrip", 1, 1);

        // Uninterrupted cooldown of 16 cycles, then hold until ack
        drive(0); drive(0); drive(0);
        release_valid();
        step();
        chk_state("cool_enter", 2, 1);
        repeat (15) step();
        chk_state("cool_last", 2, 1);
        step();
        chk_state("hold", 3, 1);
        fault_ack = 1'b1;
        step();
        fault_ack = 1'b0;
        chk_state("ack_normal", 0, 0);

        // Ack outside HOLD has no effect
        for (int i = 0; i < 8; i++) drive(4095);
        release_valid();
        step(); step();
        chk_state("trip2", 1, 1);
        fault_ack = 1'b1;
        step();
        fault_ack = 1'b0;
        chk_state("ack_tripped", 1, 1);
        repeat (3) step();
        chk_state("ack_tripped_later", 1, 1);

        // Reset in the middle of cooldown
        for (int i = 0; i < 5; i++) drive(0);
        release_valid();
        step();
        chk_state("cool2", 2, 1);
        reset = 1'b1;
        model_clear();
        step();
        reset = 1'b0;
        chk("rst2_avg_out", int'(avg_out), 0);
        chk("rst2_avg_valid", int'(avg_valid), 0);
        chk_state("rst2", 0, 0);
        drive(800);
        release_valid();
        chk("post_rst_valid", int'(avg_valid), 1);
        chk("post_rst_avg", int'(avg_out), 100);

        repeat (3) step();
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
